// File: rtl/serial_ripple_add_pkg.sv
// Shared definitions for the bit-serial ripple arithmetic blocks:
// FSM state encodings and the default operand width.
package serial_ripple_add_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_ripple_add_full_adder.sv
// Single-bit full adder used as the one-bit datapath of the serial adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic co
);

    assign sum = x ^ y ^ cin;
    assign co  = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_ripple_add.sv
// Bit-serial adder: WIDTH-bit A + B + carry-in, one full-adder step per clock,
// LSB first, with a small IDLE/SHIFT/DONE controller.
module serial_ripple_add
    import serial_ripple_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_co;
    logic             accept;
    logic             last_step;

    full_adder u_fa (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .cin (carry),
        .sum (fa_sum),
        .co  (fa_co)
    );

    // A new operation is accepted from IDLE or DONE only; SHIFT ignores start.
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == SHIFT) && (cnt == LAST_STEP);

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_co;
            // Hold on the final step so the counter never wraps.
            if (!last_step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at s[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else if (state == SHIFT) begin
            s <= {fa_sum, s[WIDTH-1:1]};
            if (last_step) begin
                cout <= fa_co;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
